// File: rtl/upsample_2d_stream_if.sv
// rtl/upsample_2d_stream_if.sv - handshake bundle for the 2x2 stream upsampler
// master drives pixels in and accepts pixels out; slave is the upsampler side.
interface upsample_2d_stream_if #(
  parameter int NBITS  = 32,
  parameter int NFMAPS = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NBITS*NFMAPS-1:0] in_act;
  logic                    out_valid;
  logic                    out_ready;
  logic [NBITS*NFMAPS-1:0] out_act;
  logic                    out_last;

  modport master (
    output in_valid, in_act, out_ready,
    input  in_ready, out_valid, out_act, out_last
  );

  modport slave (
    input  in_valid, in_act, out_ready,
    output in_ready, out_valid, out_act, out_last
  );
endinterface

// File: rtl/upsample_2d_stream.sv
// rtl/upsample_2d_stream.sv - 2x2 nearest-neighbour stream upsampler with one line buffer
// Optional UPSAMPLE_SUM_PRESERVE_EN: every output lane is arithmetically shifted right by 2.
module upsample_2d_stream #(
  parameter int NBITS  = 32,
  parameter int NFMAPS = 32,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  upsample_2d_stream_if.slave  bus
);
  localparam int DW = NBITS * NFMAPS;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   hold_data;
  logic            hold_valid;
  logic            h;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [DW-1:0]   linebuf [IMG_W];

  logic            in_fire, out_fire, row_end;
  logic [CW-1:0]   wr_col;
  logic [DW-1:0]   src_act;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign row_end  = out_fire && h && (col == COL_LAST);
  // A pixel taken back-to-back on the second copy belongs to the next column.
  assign wr_col   = hold_valid ? col + CW'(1) : col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (row_end) state_nxt = (state == FILL) ? REPLAY : FILL;
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    src_act       = hold_data;
    case (state)
      FILL: begin
        bus.in_ready  = !hold_valid || (bus.out_ready && h && (col != COL_LAST));
        bus.out_valid = hold_valid;
        src_act       = hold_data;
      end
      REPLAY: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (row == ROW_LAST) && (col == COL_LAST) && h;
        src_act       = linebuf[col];
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NFMAPS; i++) begin : g_lane
`ifdef UPSAMPLE_SUM_PRESERVE_EN
    assign bus.out_act[i*NBITS +: NBITS] = $signed(src_act[i*NBITS +: NBITS]) >>> 2;
`else
    assign bus.out_act[i*NBITS +: NBITS] = src_act[i*NBITS +: NBITS];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      h          <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      if (in_fire) begin
        hold_data  <= bus.in_act;
        hold_valid <= 1'b1;
      end else if (state == FILL && out_fire && h) begin
        hold_valid <= 1'b0;
      end
      if (out_fire) begin
        h <= !h;
        if (h) col <= (col == COL_LAST) ? '0 : col + CW'(1);
      end
      if (state == REPLAY && row_end)
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) linebuf[wr_col] <= bus.in_act;
  end
endmodule

// File: tb/tb_upsample_2d_stream.sv
// tb/tb_upsample_2d_stream.sv - randomized self-checking bench for upsample_2d_stream
// Two instances: A is 2x2, B is 1x3; both 4 lanes of 32 bits.
module tb_upsample_2d_stream;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         dsel;
  logic         drv_valid, drv_ready;
  logic [127:0] drv_act;
  logic         m_in_ready, m_out_valid, m_out_last;
  logic [127:0] m_out_act;

  upsample_2d_stream_if #(.NBITS(32), .NFMAPS(4)) if_a ();
  upsample_2d_stream_if #(.NBITS(32), .NFMAPS(4)) if_b ();

  upsample_2d_stream #(.NBITS(32), .NFMAPS(4), .IMG_W(2), .IMG_H(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  upsample_2d_stream #(.NBITS(32), .NFMAPS(4), .IMG_W(1), .IMG_H(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  assign if_a.in_valid  = drv_valid && !dsel;
  assign if_a.in_act    = drv_act;
  assign if_a.out_ready = drv_ready && !dsel;
  assign if_b.in_valid  = drv_valid && dsel;
  assign if_b.in_act    = drv_act;
  assign if_b.out_ready = drv_ready && dsel;
  assign m_in_ready  = dsel ? if_b.in_ready  : if_a.in_ready;
  assign m_out_valid = dsel ? if_b.out_valid : if_a.out_valid;
  assign m_out_act   = dsel ? if_b.out_act   : if_a.out_act;
  assign m_out_last  = dsel ? if_b.out_last  : if_a.out_last;

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] in_q[$];
  logic [127:0] exp_q[$];
  logic         last_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] xform(input logic [127:0] p);
`ifdef UPSAMPLE_SUM_PRESERVE_EN
    logic [127:0] r;
    longint       v;
    for (int i = 0; i < 4; i++) begin
      v = longint'($signed(p[i*32 +: 32]));
      v = (v >= 0) ? v / 4 : -((-v + 3) / 4);
      r[i*32 +: 32] = v[31:0];
    end
    return r;
`else
    return p;
`endif
  endfunction

  function automatic logic [127:0] rnd_px();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: every input row becomes two output rows, every pixel two beats.
  task automatic build_expected(input int w, input int hg);
    int nf;
    exp_q.delete();
    last_q.delete();
    nf = in_q.size() / (w * hg);
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < hg; r++)
        for (int rep = 0; rep < 2; rep++)
          for (int c = 0; c < w; c++)
            for (int k = 0; k < 2; k++) begin
              exp_q.push_back(xform(in_q[f*w*hg + r*w + c]));
              last_q.push_back(r == hg-1 && rep == 1 && c == w-1 && k == 1);
            end
  endtask

  task automatic run(input bit sel, input bit rnd_hs, input int abort_after, input int max_cycles);
    int w, hg, idx, beats, cyc, span, pos;
    bit held, stall, ex_ready;
    logic [127:0] pa;
    logic pl;
    w = sel ? 1 : 2;
    hg = sel ? 3 : 2;
    idx = 0; beats = 0; cyc = 0; held = 0; stall = 0; pa = '0; pl = 1'b0;
    span = (in_q.size() / (w * hg)) * hg * (4 * w + 1);
    build_expected(w, hg);
    dsel = sel;
    @(posedge clk); #1;
    while (cyc < max_cycles && exp_q.size() > 0 && !(abort_after > 0 && beats >= abort_after)) begin
      drv_valid = (idx < in_q.size()) && (!rnd_hs || held || ($urandom_range(0, 9) < 7));
      drv_act   = (idx < in_q.size()) ? in_q[idx] : '0;
      drv_ready = rnd_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stall) begin
        chk("stall_valid", m_out_valid, 1);
        chk("stall_act", m_out_act, pa);
        chk("stall_last", m_out_last, pl);
      end
      if (!rnd_hs && cyc < span) begin
        // Row period is one load cycle plus 4*w beats; in_ready only on even FILL slots.
        pos = cyc % (4 * w + 1);
        ex_ready = (pos <= 2 * w - 2) && (pos % 2 == 0);
        chk("in_ready_pattern", m_in_ready, ex_ready);
        chk("out_valid_pattern", m_out_valid, pos != 0);
      end
      if (m_out_valid && drv_ready) begin
        chk("out_act", m_out_act, exp_q[0]);
        chk("out_last", m_out_last, last_q[0]);
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
        beats++;
      end
      held = drv_valid && !m_in_ready;
      if (drv_valid && m_in_ready) idx++;
      stall = m_out_valid && !drv_ready;
      pa = m_out_act;
      pl = m_out_last;
      @(posedge clk); #1;
      cyc++;
    end
    drv_valid = 1'b0;
    if (abort_after == 0) chk("frame_complete_remaining", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; dsel = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0; drv_act = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_out_valid", if_a.out_valid, 0);
    chk("rst_a_out_last", if_a.out_last, 0);
    chk("rst_a_in_ready", if_a.in_ready, 1);
    chk("rst_b_out_valid", if_b.out_valid, 0);
    chk("rst_b_in_ready", if_b.in_ready, 1);
    rst_n = 1'b1;

    in_q = {128'd1, 128'd2, 128'd3, 128'd4};
    run(0, 0, 0, 200);
    run(0, 1, 0, 400);

    in_q = {128'hFFFFFFFF_00000001_80000000_7FFFFFFF, rnd_px(), rnd_px(), rnd_px()};
    run(0, 1, 0, 400);

    in_q.delete();
    for (int i = 0; i < 12; i++) in_q.push_back(rnd_px());
    run(0, 1, 0, 1000);

    in_q = {128'd1, 128'd2, 128'd3, 128'd4};
    run(0, 0, 5, 200);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", if_a.out_valid, 0);
    chk("abort_out_last", if_a.out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", if_a.in_ready, 1);
    run(0, 0, 0, 200);

    in_q = {128'd9, 128'd8, 128'd7, rnd_px(), rnd_px(), rnd_px()};
    run(1, 0, 0, 200);
    in_q.delete();
    for (int i = 0; i < 6; i++) in_q.push_back(rnd_px());
    run(1, 1, 0, 600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
